rotary_encoder_counter: RTL

//  Decodes one mechanical quadrature encoder (phases A/B) into validated detent steps and keeps a

---
 rtl/rotary_encoder_counter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/rotary_encoder_counter.sv
// rtl/rotary_encoder_counter.sv - quadrature encoder detent decoder with bounded position register
// Optional step acceleration is enabled by defining ROTARY_ENCODER_COUNTER_ACCEL_EN.
module rotary_encoder_counter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2,
  parameter int COUNT_WIDTH   = 8,
  parameter int COUNT_MIN     = 0,
  parameter int COUNT_MAX     = 255,
  parameter int WRAP          = 1,
  parameter int ACCEL_WINDOW  = 1000,
  parameter int ACCEL_STEP    = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_phase_a,
  input  logic                   i_phase_b,
  input  logic                   i_load,
  input  logic [COUNT_WIDTH-1:0] ia_load_value,
  output logic                   o_step,
  output logic                   o_step_cw,
  output logic [COUNT_WIDTH-1:0] oa_count,
  output logic                   o_at_limit
);

  localparam int RUN_W = $clog2(FILTER_CYCLES + 1);
  localparam int EW    = COUNT_WIDTH + 2;
  localparam logic signed [EW-1:0] MIN_S  = EW'(COUNT_MIN);
  localparam logic signed [EW-1:0] MAX_S  = EW'(COUNT_MAX);
  localparam logic signed [EW-1:0] SPAN_S = EW'(COUNT_MAX - COUNT_MIN + 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_CW_ENTER,
    S_CW_EXIT,
    S_CCW_ENTER,
    S_CCW_EXIT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             synced;
  logic [1:0]             cand;
  logic [1:0]             filt;
  logic [RUN_W-1:0]       run;
  logic [RUN_W-1:0]       run_next;
  state_t                 state;
  state_t                 state_next;
  logic                   fire;
  logic                   fire_cw;
  logic signed [EW-1:0]   inc;
  logic signed [EW-1:0]   cur;
  logic signed [EW-1:0]   up;
  logic signed [EW-1:0]   dn;
  logic signed [EW-1:0]   up_lim;
  logic signed [EW-1:0]   dn_lim;
  logic signed [EW-1:0]   ld;
  logic signed [EW-1:0]   ld_clamped;

  assign synced = {sync_b[SYNC_STAGES-1], sync_a[SYNC_STAGES-1]};

  // Run length of the synchronised value, saturating at FILTER_CYCLES.
  always_comb begin
    run_next = RUN_W'(1);
    if (synced == cand) begin
      run_next = (run == RUN_W'(FILTER_CYCLES)) ? run : run + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
      cand   <= 2'b00;
      run    <= '0;
      filt   <= 2'b00;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], i_phase_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], i_phase_b};
      cand   <= synced;
      run    <= run_next;
      if (run_next == RUN_W'(FILTER_CYCLES)) begin
        filt <= synced;
      end
    end
  end

  always_comb begin
    state_next = state;
    fire       = 1'b0;
    fire_cw    = 1'b0;
    case (state)
      S_WAIT_IDLE: if (filt == 2'b00) state_next = S_IDLE;
      S_IDLE: begin
        case (filt)
          2'b01:   state_next = S_CW_ENTER;
          2'b10:   state_next = S_CCW_ENTER;
          2'b11:   state_next = S_WAIT_IDLE;
          default: state_next = S_IDLE;
        endcase
      end
      S_CW_ENTER: begin
        if (filt == 2'b10)      state_next = S_CW_EXIT;
        else if (filt == 2'b00) state_next = S_IDLE;
      end
      S_CW_EXIT: begin
        if (filt == 2'b00) begin
          state_next = S_IDLE;
          fire       = 1'b1;
          fire_cw    = 1'b1;
        end else if (filt != 2'b10) begin
          state_next = S_CW_ENTER;
        end
      end
      S_CCW_ENTER: begin
        if (filt == 2'b01)      state_next = S_CCW_EXIT;
        else if (filt == 2'b00) state_next = S_IDLE;
      end
      S_CCW_EXIT: begin
        if (filt == 2'b00) begin
          state_next = S_IDLE;
          fire       = 1'b1;
        end else if (filt != 2'b01) begin
          state_next = S_CCW_ENTER;
        end
      end
      default: state_next = S_WAIT_IDLE;
    endcase
  end

`ifdef ROTARY_ENCODER_COUNTER_ACCEL_EN
  localparam int TW = $clog2(ACCEL_WINDOW + 1);

  logic [TW-1:0] timer;
  logic          last_cw;

  // Timer starts expired so the first step after reset always moves by one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      timer   <= TW'(ACCEL_WINDOW);
      last_cw <= 1'b0;
    end else if (fire) begin
      timer   <= '0;
      last_cw <= fire_cw;
    end else if (timer != TW'(ACCEL_WINDOW)) begin
      timer <= timer + 1'b1;
    end
  end

  assign inc = ((fire_cw == last_cw) && (timer < TW'(ACCEL_WINDOW))) ? EW'(ACCEL_STEP) : EW'(1);
`else
  logic unused_accel;

  assign inc          = EW'(1);
  assign unused_accel = ^{ACCEL_WINDOW, ACCEL_STEP};
`endif

  // Signed arithmetic with two guard bits keeps over/underflow visible before limiting.
  always_comb begin
    cur    = $signed({2'b00, oa_count});
    up     = cur + inc;
    dn     = cur - inc;
    up_lim = up;
    dn_lim = dn;
    if (up > MAX_S) up_lim = (WRAP != 0) ? up - SPAN_S : MAX_S;
    if (dn < MIN_S) dn_lim = (WRAP != 0) ? dn + SPAN_S : MIN_S;
    ld         = $signed({2'b00, ia_load_value});
    ld_clamped = ld;
    if (ld < MIN_S)      ld_clamped = MIN_S;
    else if (ld > MAX_S) ld_clamped = MAX_S;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_WAIT_IDLE;
      o_step    <= 1'b0;
      o_step_cw <= 1'b0;
      oa_count  <= COUNT_WIDTH'(COUNT_MIN);
    end else begin
      state     <= state_next;
      o_step    <= fire;
      o_step_cw <= fire_cw;
      if (i_load) begin
        oa_count <= COUNT_WIDTH'(ld_clamped);
      end else if (fire) begin
        oa_count <= COUNT_WIDTH'(fire_cw ? up_lim : dn_lim);
      end
    end
  end

  assign o_at_limit = (oa_count == COUNT_WIDTH'(COUNT_MIN)) || (oa_count == COUNT_WIDTH'(COUNT_MAX));

endmodule
